// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - time-multiplexed seven-segment scan driver
// Captures hex nibbles into a shadow register and shows one digit per refresh tick.
module seven_seg_scan #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 1000,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 0,
    parameter int BLANK_LEADING  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    // XOR masks that turn the internal active-high levels into pin levels
    localparam logic [6:0]            SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_INV  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_INV  = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

    logic [PRE_W-1:0]        r_pre;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_sh_dig;
    logic [NUM_DIGITS-1:0]   r_sh_dp;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_an;

    logic                    w_tick;
    logic [IDX_W-1:0]        w_nidx;
    logic [3:0]              w_nib;
    logic                    w_dp;
    logic                    w_nblank;
    logic                    w_lead;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [6:0]              w_seg;

    function automatic logic [6:0] seg_code(input logic [3:0] v);
        logic [6:0] c;
        case (v)
            4'h0: c = 7'h7E;
            4'h1: c = 7'h30;
            4'h2: c = 7'h6D;
            4'h3: c = 7'h79;
            4'h4: c = 7'h33;
            4'h5: c = 7'h5B;
            4'h6: c = 7'h5F;
            4'h7: c = 7'h70;
            4'h8: c = 7'h7F;
            4'h9: c = 7'h7B;
            4'hA: c = 7'h77;
            4'hB: c = 7'h1F;
            4'hC: c = 7'h4E;
            4'hD: c = 7'h3D;
            4'hE: c = 7'h4F;
            4'hF: c = 7'h47;
        endcase
        return c;
    endfunction

    assign w_tick = en && (r_pre == PRE_MAX);
    assign w_nidx = (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;

    always_comb begin
        w_nib    = 4'h0;
        w_dp     = 1'b0;
        w_nblank = 1'b0;
        w_onehot = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_nidx == IDX_W'(k)) begin
                w_nib       = r_sh_dig[4*k +: 4];
                w_dp        = r_sh_dp[k];
                w_nblank    = w_blank[k];
                w_onehot[k] = 1'b1;
            end
        end
    end

    // A digit is a leading zero when it and every digit above it are zero
    always_comb begin
        w_blank = '0;
        w_lead  = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_lead     = w_lead & (r_sh_dig[4*k +: 4] == 4'h0);
            w_blank[k] = (BLANK_LEADING != 0) && w_lead;
        end
    end

    assign w_seg = w_nblank ? 7'h00 : seg_code(w_nib);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre    <= '0;
            r_idx    <= IDX_MAX;
            r_sh_dig <= '0;
            r_sh_dp  <= '0;
            r_seg    <= SEG_INV;
            r_dp     <= DP_INV;
            r_an     <= AN_INV;
        end else begin
            if (load) begin
                r_sh_dig <= digits_in;
                r_sh_dp  <= dp_in;
            end
            if (!en) begin
                r_pre <= '0;
                r_seg <= SEG_INV;
                r_dp  <= DP_INV;
                r_an  <= AN_INV;
            end else if (w_tick) begin
                r_pre <= '0;
                r_idx <= w_nidx;
                r_seg <= w_seg ^ SEG_INV;
                r_dp  <= w_dp ^ DP_INV;
                r_an  <= w_onehot ^ AN_INV;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

    assign seg = r_seg;
    assign dp  = r_dp;
    assign an  = r_an;

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Parametrised, time-multiplexed driver for a bank of common-anode/cathode seven-segment digits. It captures a packed vector of 4-bit hex nibbles into a shadow register and scans one digit per refresh tick. For each digit it drives the segment pattern, decimal point and a one-hot digit-select. It sits between the datapath, which presents BCD/hex values, and the board display pins, and replaces per-digit combinational decoders.

## Interface
Parameters:
- NUM_DIGITS, 4: number of digits scanned, range 1..16.
- REFRESH_DIV, 1000: clocks per digit slot, range 1..2^20.
- SEG_ACTIVE_LOW, 0: 1 inverts seg and dp at the output.
- AN_ACTIVE_LOW, 0: 1 inverts an at the output.
- BLANK_LEADING, 0: 1 blanks leading zero digits.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  scan enable; 0 turns the display off.
- load  in  1  capture digits_in/dp_in into the shadow registers.
- digits_in  in  4*NUM_DIGITS  nibble k at [4k+3:4k]; digit 0 is the least significant (rightmost).
- dp_in  in  NUM_DIGITS  decimal point per digit.
- seg  out  7  {a,b,c,d,e,f,g}, registered.
- dp  out  1  decimal point for the active digit, registered.
- an  out  NUM_DIGITS  one-hot digit select, registered.

## Operation
- Segment code for logical (active-high) levels: 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47. All 16 codes are defined; there is no latch and no default gap.
- Shadow registers sh_dig and sh_dp are loaded on any clock edge where load=1, regardless of en. Otherwise they hold.
- Prescaler pre counts 0..REFRESH_DIV-1 while en=1. tick = en & (pre == REFRESH_DIV-1). pre wraps to 0 on tick. REFRESH_DIV=1 gives tick on every enabled cycle.
- Digit index idx advances on tick: if idx == NUM_DIGITS-1, the next value is 0; otherwise idx+1.
- On the tick edge, the outputs are registered for the new idx (nidx):
  - an = one-hot(nidx).
  - seg = code(sh_dig[nidx]), or 0 if that digit is blanked.
  - dp = sh_dp[nidx].
- Blanking: with BLANK_LEADING=1, digit k (k ≥ 1) is blanked when sh_dig[j] == 0 for every j with k ≤ j ≤ NUM_DIGITS-1. Digit 0 is never blanked. A blanked digit keeps its an asserted and its dp shown.
- en=0: on the next edge an goes all-inactive, seg and dp go inactive, and pre clears. idx holds. When en returns to 1, the first tick comes REFRESH_DIV cycles later and shows idx+1.
- The polarity parameters are applied only at the output registers. Internal logic is active-high.

## Timing
- Reset: pre=0, idx=NUM_DIGITS-1 (so the first tick shows digit 0), sh_dig=0, sh_dp=0. All outputs are at their inactive levels: seg/dp = all-0 (or all-1 if SEG_ACTIVE_LOW), an = all-0 (or all-1 if AN_ACTIVE_LOW).
- After reset is released with en=1, the first tick falls on clock edge REFRESH_DIV. Outputs change only on tick edges, or on the edge after en falls.
- Latency from load to display: the new value appears at the next tick edge whose slot shows that digit. If load and tick coincide, the tick uses the old shadow values.
- Reset has priority over load, en and tick. Reset asserted mid-scan returns everything to the reset state on that edge.
- Full scan period = NUM_DIGITS*REFRESH_DIV clocks. an has exactly one active bit in every cycle after the first tick while en=1.

## Test plan
- **Reset and first tick.** Parameters NUM_DIGITS=4, REFRESH_DIV=3. Reset, then load digits_in=16'h1234 with en=1.
  - Required: outputs inactive until the first tick, then an=0001 with seg=33 ('4').
  - Each 3 cycles later: an=0010/seg=79, then 0100/6D, then 1000/30, then wrap to 0001.
- **Full decode.** Parameters NUM_DIGITS=1, REFRESH_DIV=1. Load 0..F on successive cycles.
  - Required: seg follows the 16-entry table one tick after each load. an stays at 1.
- **Leading blanking.** BLANK_LEADING=1, load 16'h0050.
  - Required: digits 3 and 2 show seg=00 with an active, digit 1 shows 5B, digit 0 shows 7E.
  - Load 16'h0000: only digit 0 is lit, with 7E.
- **Polarity and dp.** SEG_ACTIVE_LOW=1, AN_ACTIVE_LOW=1, dp_in=4'b0100, load 16'h8888.
  - Required: in digit 2's slot, seg=00, dp=0, an=1011. In other slots dp=1.
  - Under reset: seg=7F, an=1111.
- **Enable gating and simultaneous load/tick.**
  - Drop en while digit 1 is shown. Required: an is inactive on the next edge. Re-enable: digit 2 appears REFRESH_DIV cycles later.
  - Assert load on a tick edge. Required: the old value is shown and the new value appears on the next pass.
- **Reset mid-scan.** Assert rst during digit 2.
  - Required: all outputs are inactive on that edge and sh_dig reads 0. After release, the first tick shows digit 0 with 7E.
